// File: rtl/trail_collision_reader.sv
// Per-frame collision check for two light-cycle bikes: probes each bike's next cell
// in the trail frame buffer, checks for walls and head-on hits, and sets sticky crash flags.
module trail_collision_reader (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [2:0]  Game_State,
    input  logic [7:0]  Blue_X,
    input  logic [7:0]  Blue_Y,
    input  logic [7:0]  Red_X,
    input  logic [7:0]  Red_Y,
    input  logic [1:0]  Blue_dir,
    input  logic [1:0]  Red_dir,
    output logic [19:0] rd_addr,
    output logic        rd_en,
    input  logic [15:0] rd_data,
    output logic        collision_blue,
    output logic        collision_red,
    output logic        check_done
);

    localparam logic [2:0] PLAYING = 3'b010;

    typedef enum logic [2:0] {IDLE, CALC, B0, B1, R0, R1, RLAST, RESOLVE} state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } cell_t;

    function automatic cell_t next_cell(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] dir);
        cell_t n;
        n.x = x;
        n.y = y;
        case (dir)
            2'b00:   n.y = y - 8'd1;
            2'b01:   n.y = y + 8'd1;
            2'b10:   n.x = x - 8'd1;
            default: n.x = x + 8'd1;
        endcase
        return n;
    endfunction

    // A step off the left/top edge wraps to 255, so one >= 224 test covers all four walls.
    function automatic logic is_wall(input cell_t c);
        return (c.x >= 8'd224) || (c.y >= 8'd224);
    endfunction

    // Each cell is two 16-bit words wide; the buffer row pitch is 1280 words with a 20-cell border.
    function automatic logic [19:0] base_addr(input cell_t c);
        return ((20'(c.x) + 20'd20) << 1) + 20'd1280 * (20'(c.y) + 20'd20);
    endfunction

    state_t      state_q, state_d;
    logic        frame_prev_q, frame_prev_d;
    cell_t       blue_nxt_q, blue_nxt_d, red_nxt_q, red_nxt_d;
    logic        blue_wall_q, blue_wall_d, red_wall_q, red_wall_d;
    logic        blue_occ_q, blue_occ_d, red_occ_q, red_occ_d;
    logic        col_blue_q, col_blue_d, col_red_q, col_red_d;

    logic        playing;
    logic [19:0] blue_base, red_base;

    assign playing   = (Game_State == PLAYING);
    assign blue_base = base_addr(blue_nxt_q);
    assign red_base  = base_addr(red_nxt_q);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        frame_prev_d = frame_clk;
        blue_nxt_d   = blue_nxt_q;
        red_nxt_d    = red_nxt_q;
        blue_wall_d  = blue_wall_q;
        red_wall_d   = red_wall_q;
        blue_occ_d   = blue_occ_q;
        red_occ_d    = red_occ_q;
        col_blue_d   = col_blue_q;
        col_red_d    = col_red_q;
        rd_en        = 1'b0;
        rd_addr      = '0;
        check_done   = 1'b0;

        case (state_q)
            IDLE: if (playing && frame_clk && !frame_prev_q) state_d = CALC;
            CALC: begin
                blue_nxt_d  = next_cell(Blue_X, Blue_Y, Blue_dir);
                red_nxt_d   = next_cell(Red_X, Red_Y, Red_dir);
                blue_wall_d = is_wall(next_cell(Blue_X, Blue_Y, Blue_dir));
                red_wall_d  = is_wall(next_cell(Red_X, Red_Y, Red_dir));
                blue_occ_d  = 1'b0;
                red_occ_d   = 1'b0;
                state_d     = B0;
            end
            B0: begin
                rd_en   = !blue_wall_q;
                rd_addr = blue_wall_q ? 20'd0 : blue_base;
                state_d = B1;
            end
            B1: begin
                rd_en   = !blue_wall_q;
                rd_addr = blue_wall_q ? 20'd0 : blue_base + 20'd1;
                if (!blue_wall_q && rd_data != 16'd0) blue_occ_d = 1'b1;
                state_d = R0;
            end
            R0: begin
                rd_en   = !red_wall_q;
                rd_addr = red_wall_q ? 20'd0 : red_base;
                if (!blue_wall_q && rd_data != 16'd0) blue_occ_d = 1'b1;
                state_d = R1;
            end
            R1: begin
                rd_en   = !red_wall_q;
                rd_addr = red_wall_q ? 20'd0 : red_base + 20'd1;
                if (!red_wall_q && rd_data != 16'd0) red_occ_d = 1'b1;
                state_d = RLAST;
            end
            RLAST: begin
                if (!red_wall_q && rd_data != 16'd0) red_occ_d = 1'b1;
                state_d = RESOLVE;
            end
            RESOLVE: begin
                col_blue_d = col_blue_q | blue_wall_q | blue_occ_q | (blue_nxt_q == red_nxt_q);
                col_red_d  = col_red_q | red_wall_q | red_occ_q | (blue_nxt_q == red_nxt_q);
                check_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Leaving play abandons any partial check and clears the crash flags.
        if (!playing) begin
            state_d    = IDLE;
            col_blue_d = 1'b0;
            col_red_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            frame_prev_q <= 1'b0;
            blue_nxt_q   <= '0;
            red_nxt_q    <= '0;
            blue_wall_q  <= 1'b0;
            red_wall_q   <= 1'b0;
            blue_occ_q   <= 1'b0;
            red_occ_q    <= 1'b0;
            col_blue_q   <= 1'b0;
            col_red_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_prev_q <= frame_prev_d;
            blue_nxt_q   <= blue_nxt_d;
            red_nxt_q    <= red_nxt_d;
            blue_wall_q  <= blue_wall_d;
            red_wall_q   <= red_wall_d;
            blue_occ_q   <= blue_occ_d;
            red_occ_q    <= red_occ_d;
            col_blue_q   <= col_blue_d;
            col_red_q    <= col_red_d;
        end
    end

    assign collision_blue = col_blue_q;
    assign collision_red  = col_red_q;

endmodule

// File: tb/tb_trail_collision_reader.sv
// Scoreboarded bench for trail_collision_reader: expected read addresses are queued when a
// check is launched and popped as the DUT issues reads; a memory model answers one cycle later.
module tb_trail_collision_reader;

    localparam logic [2:0] PLAY = 3'b010;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [2:0]  Game_State;
    logic [7:0]  Blue_X, Blue_Y, Red_X, Red_Y;
    logic [1:0]  Blue_dir, Red_dir;
    logic [19:0] rd_addr;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        collision_blue, collision_red, check_done;

    trail_collision_reader dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
        .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
        .Blue_dir(Blue_dir), .Red_dir(Red_dir),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .collision_blue(collision_blue), .collision_red(collision_red),
        .check_done(check_done)
    );

    always #10 Clk = ~Clk;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [19:0] exp_q[$];
    logic [19:0] exp_addr;
    logic [19:0] hot_addr = 20'hFFFFF;
    logic        pend = 1'b0;
    logic [19:0] pend_addr = '0;
    int          pulses;
    int          latency;

    // Read monitor: every strobe must match the next queued address.
    always @(negedge Clk) begin
        pend      = rd_en;
        pend_addr = rd_addr;
        if (rd_en === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL read_unexpected: got rd_addr=%0d, expected no read", rd_addr);
            end else begin
                exp_addr = exp_q.pop_front();
                if (rd_addr !== exp_addr) begin
                    tests_failed++;
                    $display("FAIL read_addr: got %0d, expected %0d", rd_addr, exp_addr);
                end
            end
        end
    end

    // Memory model: data one cycle after the strobe; junk when nothing was read.
    always @(posedge Clk) begin
        #1;
        if (!pend)                 rd_data = 16'hBEEF;
        else if (pend_addr == hot_addr) rd_data = 16'h0F00;
        else                       rd_data = 16'h0000;
    end

    function automatic logic [19:0] model_base(input int nx, input int ny);
        return 20'((nx + 20) * 2 + 1280 * (ny + 20));
    endfunction

    task automatic set_bikes(input logic [7:0] bx, input logic [7:0] by, input logic [1:0] bd,
                             input logic [7:0] rx, input logic [7:0] ry, input logic [1:0] rdr);
        Blue_X = bx; Blue_Y = by; Blue_dir = bd;
        Red_X = rx;  Red_Y = ry;  Red_dir = rdr;
    endtask

    task automatic clear_flags();
        @(negedge Clk) Game_State = 3'b000;
        @(negedge Clk) Game_State = PLAY;
    endtask

    // Raises frame_clk and watches 12 cycles; records check_done pulses and first latency.
    task automatic run_check(input bit retrigger);
        @(negedge Clk) frame_clk = 1'b1;
        pulses  = 0;
        latency = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            if (k == 2) frame_clk = 1'b0;
            if (retrigger && k == 3) frame_clk = 1'b1;
            if (retrigger && k == 5) frame_clk = 1'b0;
            if (check_done === 1'b1) begin
                pulses++;
                if (latency < 0) latency = k;
            end
        end
    endtask

    task automatic push_clean_reads();
        exp_q.push_back(20'd38462); exp_q.push_back(20'd38463);
        exp_q.push_back(20'd88460); exp_q.push_back(20'd88461);
    endtask

    task automatic test_reset();
        Reset = 1'b1; frame_clk = 1'b0; Game_State = PLAY; rd_data = 16'h0;
        set_bikes(8'd10, 8'd10, 2'b11, 8'd50, 8'd50, 2'b00);
        repeat (3) @(negedge Clk);
        tests_run++;
        if ({rd_en, rd_addr, check_done, collision_blue, collision_red} !== 24'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got en=%b addr=%0d done=%b cb=%b cr=%b, expected all 0",
                     rd_en, rd_addr, check_done, collision_blue, collision_red);
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_clean();
        clear_flags();
        hot_addr = 20'hFFFFF;
        set_bikes(8'd10, 8'd10, 2'b11, 8'd50, 8'd50, 2'b00);
        push_clean_reads();
        run_check(1'b0);
        tests_run++;
        if (latency != 7) begin
            tests_failed++; $display("FAIL clean_latency: got %0d, expected 7", latency);
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++; $display("FAIL clean_pulses: got %0d, expected 1", pulses);
        end
        tests_run++;
        if ({collision_blue, collision_red} !== 2'b00) begin
            tests_failed++;
            $display("FAIL clean_flags: got %b%b, expected 00", collision_blue, collision_red);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL clean_reads_left: got %0d, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_occupied();
        clear_flags();
        hot_addr = 20'd38463;
        set_bikes(8'd10, 8'd10, 2'b11, 8'd50, 8'd50, 2'b00);
        push_clean_reads();
        run_check(1'b0);
        tests_run++;
        if ({collision_blue, collision_red} !== 2'b10) begin
            tests_failed++;
            $display("FAIL occupied_flags: got %b%b, expected 10", collision_blue, collision_red);
        end
        hot_addr = 20'hFFFFF;
        push_clean_reads();
        run_check(1'b0);
        tests_run++;
        if ({collision_blue, collision_red, 4'(pulses)} !== 6'b10_0001) begin
            tests_failed++;
            $display("FAIL occupied_sticky: got flags %b%b pulses %0d, expected 10 and 1",
                     collision_blue, collision_red, pulses);
        end
    endtask

    task automatic test_wall();
        clear_flags();
        set_bikes(8'd0, 8'd5, 2'b10, 8'd50, 8'd50, 2'b00);
        exp_q.push_back(20'd88460); exp_q.push_back(20'd88461);
        run_check(1'b0);
        tests_run++;
        if ({collision_blue, collision_red} !== 2'b10) begin
            tests_failed++;
            $display("FAIL wall_flags: got %b%b, expected 10", collision_blue, collision_red);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL wall_reads_left: got %0d, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_head_on();
        clear_flags();
        set_bikes(8'd20, 8'd20, 2'b11, 8'd22, 8'd20, 2'b10);
        exp_q.push_back(20'd51282); exp_q.push_back(20'd51283);
        exp_q.push_back(20'd51282); exp_q.push_back(20'd51283);
        run_check(1'b0);
        tests_run++;
        if ({collision_blue, collision_red} !== 2'b11) begin
            tests_failed++;
            $display("FAIL head_on_flags: got %b%b, expected 11", collision_blue, collision_red);
        end
    endtask

    // Runs straight after the head-on check, so both flags start set.
    task automatic test_abort();
        bit seen_r0 = 0;
        hot_addr = 20'd38462;
        set_bikes(8'd10, 8'd10, 2'b11, 8'd50, 8'd50, 2'b00);
        exp_q.push_back(20'd38462); exp_q.push_back(20'd38463); exp_q.push_back(20'd88460);
        @(negedge Clk) frame_clk = 1'b1;
        for (int k = 0; k < 12 && !seen_r0; k++) begin
            @(negedge Clk);
            if (rd_en === 1'b1 && rd_addr === 20'd88460) seen_r0 = 1;
        end
        Game_State = 3'b000;
        tests_run++;
        if (!seen_r0) begin
            tests_failed++; $display("FAIL abort_reach_r0: got timeout, expected R0 read");
        end
        @(negedge Clk);
        tests_run++;
        if ({rd_en, rd_addr, check_done, collision_blue, collision_red} !== 24'd0) begin
            tests_failed++;
            $display("FAIL abort_outputs: got en=%b addr=%0d done=%b cb=%b cr=%b, expected all 0",
                     rd_en, rd_addr, check_done, collision_blue, collision_red);
        end
        pulses = 0;
        frame_clk = 1'b0;
        Game_State = PLAY;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            if (check_done === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 0 || collision_blue !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_discard: got pulses %0d cb=%b, expected 0 and 0", pulses, collision_blue);
        end
        hot_addr = 20'hFFFFF;
        exp_q.delete();
    endtask

    task automatic test_no_retrigger();
        clear_flags();
        set_bikes(8'd10, 8'd10, 2'b11, 8'd50, 8'd50, 2'b00);
        push_clean_reads();
        run_check(1'b1);
        tests_run++;
        if (pulses != 1) begin
            tests_failed++; $display("FAIL retrigger_pulses: got %0d, expected 1", pulses);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL retrigger_reads_left: got %0d, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Boundary table then random positions, checked against an integer model.
    task automatic test_model();
        logic [7:0] cx[2], cy[2];
        logic [1:0] cd[2];
        int         nx[2], ny[2];
        bit         wall[2], head;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin cx = '{8'd223, 8'd100}; cy = '{8'd100, 8'd0};   cd = '{2'b11, 2'b00}; end
                1: begin cx = '{8'd0,   8'd222}; cy = '{8'd223, 8'd222}; cd = '{2'b01, 2'b11}; end
                2: begin cx = '{8'd5,   8'd0};   cy = '{8'd1,   8'd223}; cd = '{2'b00, 2'b00}; end
                3: begin cx = '{8'd30,  8'd30};  cy = '{8'd40,  8'd42};  cd = '{2'b01, 2'b00}; end
                default: for (int b = 0; b < 2; b++) begin
                    cx[b] = 8'($urandom_range(0, 230));
                    cy[b] = 8'($urandom_range(0, 230));
                    cd[b] = 2'($urandom_range(0, 3));
                end
            endcase
            for (int b = 0; b < 2; b++) begin
                nx[b] = cx[b]; ny[b] = cy[b];
                if (cd[b] == 2'b00) ny[b] = (ny[b] + 255) % 256;
                if (cd[b] == 2'b01) ny[b] = (ny[b] + 1) % 256;
                if (cd[b] == 2'b10) nx[b] = (nx[b] + 255) % 256;
                if (cd[b] == 2'b11) nx[b] = (nx[b] + 1) % 256;
                wall[b] = (nx[b] >= 224) || (ny[b] >= 224);
                if (!wall[b]) begin
                    exp_q.push_back(model_base(nx[b], ny[b]));
                    exp_q.push_back(model_base(nx[b], ny[b]) + 20'd1);
                end
            end
            head = (nx[0] == nx[1]) && (ny[0] == ny[1]);
            clear_flags();
            set_bikes(cx[0], cy[0], cd[0], cx[1], cy[1], cd[1]);
            run_check(1'b0);
            tests_run++;
            if (collision_blue !== (wall[0] | head) || collision_red !== (wall[1] | head)
                || pulses != 1 || exp_q.size() != 0) begin
                tests_failed++;
                $display("FAIL model_case%0d: got cb=%b cr=%b pulses=%0d left=%0d, expected cb=%b cr=%b pulses=1 left=0",
                         i, collision_blue, collision_red, pulses, exp_q.size(),
                         wall[0] | head, wall[1] | head);
                exp_q.delete();
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen_b1 = 0;
        clear_flags();
        set_bikes(8'd20, 8'd20, 2'b11, 8'd22, 8'd20, 2'b10);
        exp_q.push_back(20'd51282); exp_q.push_back(20'd51283);
        exp_q.push_back(20'd51282); exp_q.push_back(20'd51283);
        run_check(1'b0);
        set_bikes(8'd10, 8'd10, 2'b11, 8'd50, 8'd50, 2'b00);
        exp_q.push_back(20'd38462); exp_q.push_back(20'd38463);
        @(negedge Clk) frame_clk = 1'b1;
        for (int k = 0; k < 12 && !seen_b1; k++) begin
            @(negedge Clk);
            if (rd_en === 1'b1 && rd_addr === 20'd38463) seen_b1 = 1;
        end
        Reset = 1'b1;
        @(negedge Clk);
        tests_run++;
        if (!seen_b1 || {rd_en, rd_addr, check_done, collision_blue, collision_red} !== 24'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got seen=%b en=%b addr=%0d done=%b cb=%b cr=%b, expected 1 and all 0",
                     seen_b1, rd_en, rd_addr, check_done, collision_blue, collision_red);
        end
        // frame_clk stays high through reset; a cleared history sees a fresh edge.
        push_clean_reads();
        @(negedge Clk) Reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            if (check_done === 1'b1) pulses++;
        end
        frame_clk = 1'b0;
        tests_run++;
        if (pulses != 1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_history: got pulses %0d left %0d, expected 1 and 0", pulses, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_occupied();
        test_wall();
        test_head_on();
        test_abort();
        test_no_retrigger();
        test_model();
        test_reset_mid();
        repeat (2) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
